// File: rtl/async_fifo_lvl.sv
// Dual-clock FWFT FIFO with Gray-coded pointers, per-domain fill levels,
// programmable almost-full/almost-empty and sticky overflow/underflow flags.
module async_fifo_lvl #(
   parameter int D_SIZE      = 16,
   parameter int A_SIZE      = 3,
   parameter int SYNC_STAGES = 2,
   parameter int AF_LVL      = 6,
   parameter int AE_LVL      = 2
) (
   input  logic              w_clk,
   input  logic              w_rstn,
   input  logic              r_clk,
   input  logic              r_rstn,
   input  logic              w_inc,
   input  logic [D_SIZE-1:0] w_data,
   output logic              w_full,
   output logic              w_afull,
   output logic [A_SIZE:0]   w_level,
   output logic              w_ovf,
   input  logic              w_ovf_clr,
   input  logic              r_inc,
   output logic [D_SIZE-1:0] r_data,
   output logic              r_empty,
   output logic              r_aempty,
   output logic [A_SIZE:0]   r_level,
   output logic              r_udf,
   input  logic              r_udf_clr
);

   localparam int DEPTH = 2**A_SIZE;
   localparam logic [A_SIZE:0] AF_THR = (A_SIZE+1)'(AF_LVL);
   localparam logic [A_SIZE:0] AE_THR = (A_SIZE+1)'(AE_LVL);

   logic [D_SIZE-1:0] mem [DEPTH];

   logic [A_SIZE:0] w_bin, w_bin_nxt, w_gray, rq_gray, rq_bin;
   logic [A_SIZE:0] r_bin, r_bin_nxt, r_gray, wq_gray, wq_bin;
   logic [A_SIZE:0] rq_sync [SYNC_STAGES];
   logic [A_SIZE:0] wq_sync [SYNC_STAGES];
   logic            w_push, r_pop;

   function automatic logic [A_SIZE:0] bin2gray(input logic [A_SIZE:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [A_SIZE:0] gray2bin(input logic [A_SIZE:0] g);
      logic [A_SIZE:0] b;
      b[A_SIZE] = g[A_SIZE];
      for (int i = A_SIZE - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
      return b;
   endfunction

   // ---------------- write domain ----------------
   assign w_push    = w_inc & ~w_full;
   assign w_bin_nxt = w_bin + (A_SIZE+1)'(w_push);

   // NOTE: state flops use non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge w_clk or negedge w_rstn) begin
      if (!w_rstn) begin
         w_bin  <= '0;
         w_gray <= '0;
         w_ovf  <= 1'b0;
      end else begin
         w_bin  <= w_bin_nxt;
         w_gray <= bin2gray(w_bin_nxt);
         if (w_inc && w_full) w_ovf <= 1'b1;
         else if (w_ovf_clr)  w_ovf <= 1'b0;
      end
   end

   // NOTE: the storage array is deliberately not reset; the pointers alone
   // define which entries are valid, and a reset would block RAM inference.
   always_ff @(posedge w_clk) begin
      if (w_push) mem[w_bin[A_SIZE-1:0]] <= w_data;
   end

   always_ff @(posedge w_clk or negedge w_rstn) begin
      if (!w_rstn) begin
         for (int i = 0; i < SYNC_STAGES; i++) rq_sync[i] <= '0;
      end else begin
         rq_sync[0] <= r_gray;
         for (int i = 1; i < SYNC_STAGES; i++) rq_sync[i] <= rq_sync[i-1];
      end
   end

   assign rq_gray = rq_sync[SYNC_STAGES-1];
   assign rq_bin  = gray2bin(rq_gray);
   // Full: write pointer is one lap ahead of the synchronised read pointer.
   assign w_full  = (w_gray == {~rq_gray[A_SIZE:A_SIZE-1], rq_gray[A_SIZE-2:0]});
   assign w_level = w_bin - rq_bin;
   assign w_afull = (w_level >= AF_THR);

   // ---------------- read domain ----------------
   assign r_pop     = r_inc & ~r_empty;
   assign r_bin_nxt = r_bin + (A_SIZE+1)'(r_pop);

   always_ff @(posedge r_clk or negedge r_rstn) begin
      if (!r_rstn) begin
         r_bin  <= '0;
         r_gray <= '0;
         r_udf  <= 1'b0;
      end else begin
         r_bin  <= r_bin_nxt;
         r_gray <= bin2gray(r_bin_nxt);
         if (r_inc && r_empty) r_udf <= 1'b1;
         else if (r_udf_clr)   r_udf <= 1'b0;
      end
   end

   always_ff @(posedge r_clk or negedge r_rstn) begin
      if (!r_rstn) begin
         for (int i = 0; i < SYNC_STAGES; i++) wq_sync[i] <= '0;
      end else begin
         wq_sync[0] <= w_gray;
         for (int i = 1; i < SYNC_STAGES; i++) wq_sync[i] <= wq_sync[i-1];
      end
   end

   assign wq_gray  = wq_sync[SYNC_STAGES-1];
   assign wq_bin   = gray2bin(wq_gray);
   assign r_empty  = (r_gray == wq_gray);
   assign r_level  = wq_bin - r_bin;
   assign r_aempty = (r_level <= AE_THR);
   assign r_data   = mem[r_bin[A_SIZE-1:0]];

endmodule

// File: tb/tb_async_fifo_lvl.sv
// Self-checking bench for async_fifo_lvl: directed corner cases on the default
// and a 32-deep build, plus randomized streaming against a queue model.
`timescale 1ns/1ps
module tb_async_fifo_lvl;

   localparam int DEPTH = 8;

   logic w_clk = 1'b0, r_clk = 1'b0;
   logic w_rstn, r_rstn;
   realtime w_half = 5.0, r_half = 13.514;
   always #(w_half) w_clk = ~w_clk;
   always #(r_half) r_clk = ~r_clk;

   // default build
   logic        w_inc, w_full, w_afull, w_ovf, w_ovf_clr;
   logic [15:0] w_data, r_data;
   logic [3:0]  w_level, r_level;
   logic        r_inc, r_empty, r_aempty, r_udf, r_udf_clr;

   async_fifo_lvl dut (
      .w_clk(w_clk), .w_rstn(w_rstn), .r_clk(r_clk), .r_rstn(r_rstn),
      .w_inc(w_inc), .w_data(w_data), .w_full(w_full), .w_afull(w_afull),
      .w_level(w_level), .w_ovf(w_ovf), .w_ovf_clr(w_ovf_clr),
      .r_inc(r_inc), .r_data(r_data), .r_empty(r_empty), .r_aempty(r_aempty),
      .r_level(r_level), .r_udf(r_udf), .r_udf_clr(r_udf_clr)
   );

   // 32-deep build, 3-stage synchronisers
   logic        b_w_inc, b_w_full, b_w_afull, b_w_ovf;
   logic [15:0] b_w_data, b_r_data;
   logic [5:0]  b_w_level, b_r_level;
   logic        b_r_inc, b_r_empty, b_r_aempty, b_r_udf;

   async_fifo_lvl #(.D_SIZE(16), .A_SIZE(5), .SYNC_STAGES(3), .AF_LVL(30), .AE_LVL(4)) dut_b (
      .w_clk(w_clk), .w_rstn(w_rstn), .r_clk(r_clk), .r_rstn(r_rstn),
      .w_inc(b_w_inc), .w_data(b_w_data), .w_full(b_w_full), .w_afull(b_w_afull),
      .w_level(b_w_level), .w_ovf(b_w_ovf), .w_ovf_clr(1'b0),
      .r_inc(b_r_inc), .r_data(b_r_data), .r_empty(b_r_empty), .r_aempty(b_r_aempty),
      .r_level(b_r_level), .r_udf(b_r_udf), .r_udf_clr(1'b0)
   );

   int errs = 0, checks = 0;
   logic [15:0] sb[$];
   int wr_cnt, rd_cnt;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errs++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic do_reset();
      w_inc = 1'b0; w_data = '0; w_ovf_clr = 1'b0;
      r_inc = 1'b0; r_udf_clr = 1'b0;
      b_w_inc = 1'b0; b_w_data = '0; b_r_inc = 1'b0;
      w_rstn = 1'b0; r_rstn = 1'b0;
      sb.delete(); wr_cnt = 0; rd_cnt = 0;
      #100;
      @(negedge w_clk) w_rstn = 1'b1;
      @(negedge r_clk) r_rstn = 1'b1;
      repeat (3) @(negedge r_clk);
      @(negedge w_clk);
   endtask

   task automatic rand_writer(input int n);
      int acc = 0, cyc = 0;
      while (acc < n && cyc < 20000) begin
         @(negedge w_clk); cyc++;
         // w_level may over-report occupancy, never under-report it
         check("wlvl_ge_occ", 32'(int'(w_level) >= wr_cnt - rd_cnt), 1);
         check("wfull_lvl", w_full, w_level == DEPTH);
         w_inc  = ($urandom_range(0, 3) != 0);
         w_data = 16'($urandom);
         if (w_inc && !w_full) begin
            sb.push_back(w_data);
            wr_cnt++; acc++;
         end
      end
      @(negedge w_clk) w_inc = 1'b0;
      check("wr_done", acc, n);
   endtask

   task automatic rand_reader(input int n);
      int pops = 0, cyc = 0;
      while (pops < n && cyc < 20000) begin
         @(negedge r_clk); cyc++;
         check("rlvl_le_occ", 32'(int'(r_level) <= wr_cnt - rd_cnt), 1);
         check("rempty_lvl", r_empty, r_level == 0);
         r_inc = ($urandom_range(0, 2) != 0);
         if (r_inc && !r_empty) begin
            if (sb.size() == 0) check("sb_underrun", 0, 1);
            else check("rnd_data", r_data, sb.pop_front());
            rd_cnt++; pops++;
         end
      end
      @(negedge r_clk) r_inc = 1'b0;
      check("rd_done", pops, n);
   endtask

   initial begin
      int k;
      do_reset();

      // reset state
      check("rst_w_full", w_full, 0);
      check("rst_w_afull", w_afull, 0);
      check("rst_w_level", w_level, 0);
      check("rst_w_ovf", w_ovf, 0);
      check("rst_r_empty", r_empty, 1);
      check("rst_r_aempty", r_aempty, 1);
      check("rst_r_level", r_level, 0);
      check("rst_r_udf", r_udf, 0);
      check("rst_b_r_empty", b_r_empty, 1);
      check("rst_b_w_full", b_w_full, 0);

      // fill 8 words back-to-back
      for (int i = 1; i <= 8; i++) begin
         w_inc = 1'b1; w_data = 16'(i);
         @(negedge w_clk);
         check("fill_level", w_level, i);
         check("fill_afull", w_afull, i >= 6);
         check("fill_full", w_full, i == 8);
      end
      w_inc = 1'b0;
      for (k = 0; k < 3; k++) begin
         @(negedge r_clk);
         if (r_level == 8) break;
      end
      check("rlvl_reach_8", r_level, 8);

      // overflow while full
      @(negedge w_clk); w_inc = 1'b1; w_data = 16'hDEAD;
      @(negedge w_clk); w_inc = 1'b0;
      check("ovf_set", w_ovf, 1);
      check("ovf_level", w_level, 8);
      @(negedge w_clk);
      check("ovf_sticky", w_ovf, 1);
      w_ovf_clr = 1'b1;
      @(negedge w_clk); w_ovf_clr = 1'b0;
      check("ovf_clr", w_ovf, 0);

      // drain, in order, with almost-empty tracking
      @(negedge r_clk);
      for (int i = 1; i <= 8; i++) begin
         check("drain_nempty", r_empty, 0);
         check("drain_data", r_data, i);
         check("drain_aempty", r_aempty, (9 - i) <= 2);
         r_inc = 1'b1;
         @(negedge r_clk);
      end
      r_inc = 1'b0;
      check("drain_empty", r_empty, 1);
      check("drain_rlvl", r_level, 0);
      check("drain_udf", r_udf, 0);
      r_inc = 1'b1;
      @(negedge r_clk); r_inc = 1'b0;
      check("udf_set", r_udf, 1);
      r_inc = 1'b1; r_udf_clr = 1'b1;
      @(negedge r_clk); r_inc = 1'b0; r_udf_clr = 1'b0;
      check("udf_set_wins", r_udf, 1);
      r_udf_clr = 1'b1;
      @(negedge r_clk); r_udf_clr = 1'b0;
      check("udf_clr", r_udf, 0);
      for (k = 0; k < 6; k++) begin
         @(negedge w_clk);
         if (w_level == 0) break;
      end
      check("wlvl_release", w_level, 0);
      check("wfull_release", w_full, 0);

      // 32-deep build: empty latency, thresholds, full at 32
      @(negedge w_clk); b_w_inc = 1'b1; b_w_data = 16'h1234;
      @(posedge w_clk); #1 b_w_inc = 1'b0;
      for (k = 1; k <= 6; k++) begin
         @(posedge r_clk); #1;
         if (!b_r_empty) break;
      end
      check("b_empty_lat", 32'(k <= 5), 1);
      @(negedge r_clk);
      check("b_first_data", b_r_data, 16'h1234);
      b_r_inc = 1'b1;
      @(negedge r_clk); b_r_inc = 1'b0;
      check("b_empty_again", b_r_empty, 1);
      for (k = 0; k < 8; k++) begin
         @(negedge w_clk);
         if (b_w_level == 0) break;
      end
      check("b_wlvl_zero", b_w_level, 0);
      for (int i = 1; i <= 32; i++) begin
         b_w_inc = 1'b1; b_w_data = 16'(16'h100 + i);
         @(negedge w_clk);
         check("b_fill_level", b_w_level, i);
         check("b_fill_afull", b_w_afull, i >= 30);
         check("b_fill_full", b_w_full, i == 32);
      end
      b_w_inc = 1'b0;
      for (k = 0; k < 6; k++) begin
         @(negedge r_clk);
         if (b_r_level == 32) break;
      end
      check("b_rlvl_32", b_r_level, 32);
      for (int i = 1; i <= 32; i++) begin
         check("b_drain_data", b_r_data, 16'h100 + i);
         check("b_drain_aempty", b_r_aempty, (33 - i) <= 4);
         b_r_inc = 1'b1;
         @(negedge r_clk);
      end
      b_r_inc = 1'b0;
      check("b_drain_empty", b_r_empty, 1);
      check("b_no_udf", b_r_udf, 0);
      check("b_no_ovf", b_w_ovf, 0);

      // random streaming, fast write / slow read
      do_reset();
      fork
         rand_writer(1000);
         rand_reader(1000);
      join
      check("sb_empty_fs", sb.size(), 0);
      check("fs_final_empty", r_empty, 1);

      // random streaming, slow write / fast read
      w_half = 13.514; r_half = 5.0;
      do_reset();
      fork
         rand_writer(1000);
         rand_reader(1000);
      join
      check("sb_empty_sf", sb.size(), 0);
      check("sf_final_empty", r_empty, 1);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/async_fifo_lvl.md
# async_fifo_lvl

Parametrised dual-clock FIFO; successor to the fixed 8-deep, 4-bit-pointer async FIFO in the UART path. Depth is any power of two, synchroniser depth is configurable, and pointer Gray coding is generic instead of table-driven. Each domain gets a fill level, programmable almost-full/almost-empty flags and sticky overflow/underflow error flags. It sits between the UART core clock domain (write) and the system/register clock domain (read). The first-word-fall-through read port connects directly to the register interface.

## Interface
- D_SIZE, 16, data width in bits.
- A_SIZE, 3, address width; depth DEPTH = 2**A_SIZE (A_SIZE >= 2).
- SYNC_STAGES, 2, flops per pointer synchroniser (>= 2).
- AF_LVL, 6, w_afull asserts when w_level >= AF_LVL (1..DEPTH).
- AE_LVL, 2, r_aempty asserts when r_level <= AE_LVL (0..DEPTH-1).

Ports:
- w_clk  in  1  write clock.
- w_rstn  in  1  write-domain reset, asynchronous, active-low.
- r_clk  in  1  read clock.
- r_rstn  in  1  read-domain reset, asynchronous, active-low.
- w_inc  in  1  write request.
- w_data  in  D_SIZE  write data.
- w_full  out  1  FIFO full as seen by the write domain.
- w_afull  out  1  almost full.
- w_level  out  A_SIZE+1  write-side fill level, 0..DEPTH.
- w_ovf  out  1  sticky overflow (write while full).
- w_ovf_clr  in  1  clears w_ovf.
- r_inc  in  1  read/pop request.
- r_data  out  D_SIZE  head-of-FIFO data (FWFT).
- r_empty  out  1  FIFO empty as seen by the read domain.
- r_aempty  out  1  almost empty.
- r_level  out  A_SIZE+1  read-side fill level, 0..DEPTH.
- r_udf  out  1  sticky underflow (read while empty).
- r_udf_clr  in  1  clears r_udf.

## Operation
- Pointers:
  - Binary w_bin and r_bin are A_SIZE+1 bits and wrap mod 2**(A_SIZE+1). Memory address is the low A_SIZE bits.
  - Gray pointers are registered from the next binary value: gray = b ^ (b >> 1). Gray therefore always equals gray(current binary), with no extra cycle of lag.
- Synchronisers: w_gray goes to the r_clk domain and r_gray goes to the w_clk domain. Each is a SYNC_STAGES flop chain reset by the destination-domain reset. The synchronised Gray value is converted back to binary in the destination domain.
- Write:
  - Accepted when w_inc && !w_full. Memory is written at w_bin[A_SIZE-1:0] and w_bin increments.
  - w_inc && w_full drops the data, leaves the pointer unchanged and sets w_ovf.
- Read:
  - r_data = mem[r_bin[A_SIZE-1:0]] combinationally. Its value is don't-care while r_empty = 1.
  - Pop when r_inc && !r_empty. r_inc && r_empty sets r_udf; r_bin is unchanged.
- Flags and levels (all derived from flops only, no input-to-output paths):
  - w_full = (w_gray == {~rq_gray[A_SIZE:A_SIZE-1], rq_gray[A_SIZE-2:0]}).
  - r_empty = (r_gray == wq_gray).
  - w_level = w_bin - rq_bin; r_level = wq_bin - r_bin (mod 2**(A_SIZE+1)).
  - w_afull = (w_level >= AF_LVL); r_aempty = (r_level <= AE_LVL).
- Sticky flags: if set and clear occur in the same cycle, set wins.
- Memory array has no reset.
- Levels are conservative: w_level may over-report and r_level may under-report by in-flight synchroniser latency. Never the reverse.

## Timing
- Reset values:
  - Write domain: w_full = 0, w_afull = 0 (with AF_LVL >= 1), w_level = 0, w_ovf = 0.
  - Read domain: r_empty = 1, r_aempty = 1, r_level = 0, r_udf = 0.
- Write-side flags update on the w_clk edge that accepts the write. w_full asserts on the edge accepting the DEPTH-th outstanding word.
- Write-to-read latency: r_empty deasserts SYNC_STAGES+1 r_clk edges after the accepting w_clk edge (±1 edge for phase).
- Read-to-write latency: w_full deasserts SYNC_STAGES+1 w_clk edges after the popping r_clk edge (±1 edge).
- Simultaneous write and read when neither full nor empty: both proceed; each level reflects its own operation immediately.
- Wrap-around: pointers wrap after 2**(A_SIZE+1) operations with no flag glitch.
- Reset rules:
  - Both resets must be asserted together for a system reset. Resetting one domain alone is unsupported.
  - Reset mid-operation discards contents.

## Test plan
- Reset with w_clk = 100 MHz, r_clk = 37 MHz, defaults → r_empty = 1, r_aempty = 1, w_full = 0, both levels 0, w_ovf = r_udf = 0.
- Write 8 words 0x0001..0x0008 back-to-back, no reads:
  - w_full = 1 after the 8th accept; w_afull = 1 from the 6th; w_level = 8.
  - Read side: r_level reaches 8 within 3 r_clk edges of the last write.
- Write a 9th word 0xDEAD while full → dropped, w_ovf = 1 stays set. Pulse w_ovf_clr → w_ovf = 0.
- Drain all 8 → r_data sequence 0x0001..0x0008, then r_empty = 1. Extra r_inc sets r_udf. Simultaneous r_inc and r_udf_clr on an empty FIFO → r_udf stays 1.
- Stream 1000 random words with random w_inc/r_inc on both clock-ratio orders (fast/slow, slow/fast):
  - Scoreboard: data exact and in order.
  - No write accepted while w_full; no pop while r_empty.
  - Pointers wrap ≥ 60 times.
- Rebuild with A_SIZE = 5, SYNC_STAGES = 3, AF_LVL = 30, AE_LVL = 4 → full at 32 words, w_afull at 30, r_aempty while r_level <= 4, empty latency ≤ 5 r_clk edges.
